// File: rtl/seq_tx.sv
// seq_tx: serial pattern transmitter that shifts a 1..WIDTH bit word out on w, one bit per clk.
// Define SEQ_TX_LSB_FIRST_EN to send data_in[0] first instead of data_in[len-1].
module seq_tx #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CW-1:0]    len,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             w,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, next_state;
    logic [CW-1:0]    count, next_count, eff_len;
    logic [WIDTH-1:0] shreg, next_shreg, load_rest, shift_rest;
    logic             load_first, shift_bit, accept;
    logic             next_w, next_busy, next_done;

    // A zero or oversized length means a full-width word.
    always_comb begin
        eff_len = len;
        if (len == '0 || len > CW'(WIDTH))
            eff_len = CW'(WIDTH);
    end

`ifdef SEQ_TX_LSB_FIRST_EN
    // LSB first: bits above the field are never reached because the counter stops first.
    always_comb begin
        load_first = data_in[0];
        load_rest  = data_in >> 1;
        shift_bit  = shreg[0];
        shift_rest = shreg >> 1;
    end
`else
    // MSB first: left-align the field so the next bit to send is always shreg[WIDTH-1].
    logic [WIDTH-1:0] aligned;

    always_comb begin
        aligned    = data_in << (CW'(WIDTH) - eff_len);
        load_first = aligned[WIDTH-1];
        load_rest  = aligned << 1;
        shift_bit  = shreg[WIDTH-1];
        shift_rest = shreg << 1;
    end
`endif

    // Ready while idle, and during the last bit so back-to-back words leave no gap.
    assign load_ready = (state == IDLE) || (count == CW'(1));
    assign accept     = load_valid && load_ready;

    always_comb begin
        next_state = state;
        next_count = count;
        next_shreg = shreg;
        next_w     = 1'b0;
        next_busy  = 1'b0;
        next_done  = 1'b0;
        case (state)
            IDLE: ;
            SHIFT: begin
                if (count == CW'(1)) begin
                    next_done  = 1'b1;
                    next_state = IDLE;
                    next_count = '0;
                    next_shreg = '0;
                end else begin
                    next_w     = shift_bit;
                    next_shreg = shift_rest;
                    next_count = count - CW'(1);
                    next_busy  = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        // A new word overrides the return to idle but keeps the done pulse.
        if (accept) begin
            next_state = SHIFT;
            next_count = eff_len;
            next_w     = load_first;
            next_shreg = load_rest;
            next_busy  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            shreg <= '0;
            w     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            shreg <= next_shreg;
            w     <= next_w;
            busy  <= next_busy;
            done  <= next_done;
        end
    end

endmodule

// File: doc/seq_tx.md
# seq_tx

Serial pattern transmitter producing the single-bit `w` stream consumed by the sequence-detector FSMs of this exercise set. It accepts a parallel word plus a bit count through a valid/ready handshake and shifts it out one bit per `clk` rising edge. It sits in front of a detector (`w` → detector `w`), replacing hand-written stimulus with a synthesizable source.

## Interface
- `WIDTH`, default 8: maximum word length in bits (≥ 2).
- `CW`, default `$clog2(WIDTH+1)`: width of the length field and bit counter.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `data_in` input WIDTH: word to send; bits `[len-1:0]` are used and the rest are ignored.
- `len` input CW: number of bits to send, 1..WIDTH; 0 or >WIDTH is treated as WIDTH.
- `load_valid` input 1: source offers `data_in`/`len`.
- `load_ready` output 1: transmitter can accept a word this cycle.
- `w` output 1: serial bit stream; idle level 0.
- `busy` output 1: a word is being shifted out.
- `done` output 1: single-cycle pulse after the last bit of a word.

## Operation
- All outputs are registered, except `load_ready`, which is combinational from state and counter.
- Reset values: `w`=0, `busy`=0, `done`=0, `load_ready`=1, state IDLE, counter 0, shift register 0.
- States:
  - IDLE: `busy`=0, `w`=0, `load_ready`=1.
  - SHIFT: `busy`=1.
- Transfer: a word is accepted on any rising edge where `load_valid && load_ready`. `data_in` and the effective `len` are captured, and the counter is set to `len`.
- `load_ready` is 1 in IDLE, and also in SHIFT when counter==1 (last bit on `w`). This allows back-to-back words with no idle gap. Otherwise it is 0.
- SHIFT: each edge advances one bit and decrements the counter.
  - When the counter reaches 1 and no new transfer occurs, the next edge returns to IDLE with `w`=0.
  - If a transfer occurs on that edge, the state stays SHIFT, the new word is loaded, and `w` takes its first bit.
- Bit order, default: MSB-of-field first. Sequence is `data_in[len-1]`, `data_in[len-2]`, …, `data_in[0]`.
- `done`: set to 1 on the edge that ends the last bit of a word, and cleared on the following edge. This includes the back-to-back case, where `done`=1 coincides with the next word's first bit.
- `load_valid` while `load_ready`=0 is ignored. No capture occurs, and the source must hold its word.
- Reset mid-word: asserting `reset` immediately forces the reset values and discards the partially sent word. No `done` is produced for it.

## Timing
- Latency: the word accepted at edge k drives its first bit on `w` from edge k until edge k+1.
- Bit i (0-based send order) occupies `w` between edges k+i and k+i+1.
- The last bit ends at edge k+len. At that edge `done` goes to 1, and `busy`/`w` go to 0 unless a new word was accepted.
- Throughput: 1 bit per cycle sustained with continuous back-to-back loads.
- A single-bit word (len=1) asserts `load_ready` in its only SHIFT cycle.

## Configuration
- `SEQ_TX_LSB_FIRST_EN`:
  - Defined: bit order is reversed, sending `data_in[0]` first and `data_in[len-1]` last.
  - Undefined: MSB-of-field first, as described above.
- Handshake, timing, and `done` behaviour are identical in both builds.

## Test plan
- Reset, then idle for 3 cycles → `w`=0, `busy`=0, `done`=0, `load_ready`=1 throughout.
- Load `len`=5, `data_in`=8'b0001_0011 → `w` = 1,0,0,1,1 on 5 consecutive cycles, `busy`=1 for exactly 5 cycles, `done` pulses once, then `w`=0. With `SEQ_TX_LSB_FIRST_EN` → `w` = 1,1,0,0,1.
- Back-to-back: `len`=3 `data_in`=3'b101, with `load_valid` held and the next word `len`=2 `data_in`=2'b01 → `w` = 1,0,1,0,1 with no gap, accepted on edges 0 and 3, `done` high in cycles 3 and 5.
- `load_valid`=1 mid-word (counter>1) with a different `data_in` → not captured, the current word completes unchanged, and the new word is taken only when `load_ready`=1.
- `len`=0 and `len`=1: `len`=0 with `data_in`=8'hA5 → 8 bits 1,0,1,0,0,1,0,1. `len`=1 with `data_in[0]`=1 → single `w`=1 cycle, then `done`.
- Assert `reset` asynchronously during bit 3 of an 8-bit word → `w`/`busy` drop to 0 before the next edge, no `done`, and a fresh load after release transmits correctly.
